// File: rtl/mathbox_div_pkg.sv
// Shared types and chain mode encodings for the math-box divider sequencer.
package mathbox_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } div_state_t;

  // {S1,S0} encodings understood by the universal shift cells
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/quot_shift_chain.sv
// Cascade of WIDTH/8 universal 8-bit shift cells forming the quotient register.
// Shift-left feeds ds0 into bit 0; shift-right feeds ds7 into the top bit.
module quot_shift_chain
  import mathbox_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             ds0,
  input  logic             ds7,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             msb
);

  localparam int CELLS = WIDTH / 8;

  logic [WIDTH-1:0] chain_q;

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    logic [7:0] cell_q;
    logic       shl_in;
    logic       shr_in;

    if (i == 0) begin : g_shl_src
      assign shl_in = ds0;
    end else begin : g_shl_src
      assign shl_in = chain_q[8*i-1];
    end

    if (i == CELLS - 1) begin : g_shr_src
      assign shr_in = ds7;
    end else begin : g_shr_src
      assign shr_in = chain_q[8*(i+1)];
    end

    // One shift cell: hold, shift right, shift left or parallel load by mode
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cell_q <= '0;
      end else begin
        case (mode)
          MODE_HOLD: cell_q <= cell_q;
          MODE_SHR:  cell_q <= {shr_in, cell_q[7:1]};
          MODE_SHL:  cell_q <= {cell_q[6:0], shl_in};
          default:   cell_q <= par_in[8*i +: 8];
        endcase
      end
    end

    assign chain_q[8*i +: 8] = cell_q;
  end

  assign par_out = chain_q;
  assign msb     = chain_q[WIDTH-1];

endmodule

// File: rtl/mathbox_div_sequencer.sv
// Restoring divider sequencer driving the quotient shift chain.
// Optional feature: MATHBOX_DIV_ZERO_DETECT_EN short-circuits a zero divisor
// (flags div_by_zero, skips the shift steps). Undefined: div_by_zero is 0
// and a zero divisor runs the normal WIDTH-step algorithm.
module mathbox_div_sequencer
  import mathbox_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       shift_mode
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic [WIDTH-1:0] chain_in;
  logic             chain_msb;
  logic [WIDTH:0]   partial;
  logic             borrow;
  logic             unused_trial_bit;
  logic [WIDTH-1:0] trial_rem;
  logic             step_en;

  // Trial subtraction is WIDTH+2 wide so the top bit is the borrow
  assign partial = {remainder_reg, chain_msb};
  assign {borrow, unused_trial_bit, trial_rem} = {1'b0, partial} - {2'b00, divisor_reg};

`ifdef MATHBOX_DIV_ZERO_DETECT_EN
  logic dz_q;
  assign div_by_zero = dz_q;
  assign chain_in    = (divisor_reg == '0) ? '1 : dividend_reg;
`else
  assign div_by_zero = 1'b0;
  assign chain_in    = dividend_reg;
`endif

  // A flagged zero divide freezes the remainder during its single wait step
  assign step_en = ~div_by_zero;

  quot_shift_chain #(.WIDTH(WIDTH)) u_chain (
    .clk     (clk),
    .reset   (reset),
    .mode    (shift_mode),
    .ds0     (~borrow),
    .ds7     (1'b0),
    .par_in  (chain_in),
    .par_out (quotient),
    .msb     (chain_msb)
  );

  assign remainder = remainder_reg;

  // Sequencer FSM: registered mode/busy/done are set on entry to each state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      remainder_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      shift_mode    <= MODE_HOLD;
`ifdef MATHBOX_DIV_ZERO_DETECT_EN
      dz_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            busy         <= 1'b1;
            shift_mode   <= MODE_LOAD;
            state        <= LOAD;
          end
        end
        LOAD: begin
          remainder_reg <= '0;
          counter       <= CW'(WIDTH);
          shift_mode    <= MODE_SHL;
          state         <= SHIFT;
`ifdef MATHBOX_DIV_ZERO_DETECT_EN
          dz_q          <= 1'b0;
          if (divisor_reg == '0) begin
            dz_q          <= 1'b1;
            remainder_reg <= dividend_reg;
            counter       <= CW'(1);
            shift_mode    <= MODE_HOLD;
          end
`endif
        end
        SHIFT: begin
          if (step_en) begin
            remainder_reg <= borrow ? partial[WIDTH-1:0] : trial_rem;
          end
          counter <= counter - CW'(1);
          if (counter == CW'(1)) begin
            shift_mode <= MODE_HOLD;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mathbox_div_sequencer.sv
// Self-checking bench for mathbox_div_sequencer against an arithmetic divide model.
module tb_mathbox_div_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic [1:0]       shift_mode;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_r;

  mathbox_div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .shift_mode  (shift_mode)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Runs one division from an IDLE negedge; inject_at pulses a stray start,
  // abort_at asserts reset at that cycle (0 disables either)
  task automatic applyStimulus(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                               input int inject_at, input int abort_at);
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_r;
    logic             exp_dz;
    logic [1:0]       exp_mode;
    int               exp_lat;

    if (dv == '0) begin
      exp_q = '1;
      exp_r = dd;
    end else begin
      exp_q = dd / dv;
      exp_r = dd % dv;
    end
`ifdef MATHBOX_DIV_ZERO_DETECT_EN
    exp_dz  = (dv == '0);
    exp_lat = exp_dz ? 3 : WIDTH + 2;
`else
    exp_dz  = 1'b0;
    exp_lat = WIDTH + 2;
`endif

    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      @(negedge clk);
      start    = (k == inject_at);
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        checkOutput("abort_quotient", quotient, '0);
        checkOutput("abort_remainder", remainder, '0);
        checkOutput("abort_busy", WIDTH'(busy), '0);
        checkOutput("abort_done", WIDTH'(done), '0);
        checkOutput("abort_mode", WIDTH'(shift_mode), '0);
        checkOutput("abort_dz", WIDTH'(div_by_zero), '0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("post_abort_busy", WIDTH'(busy), '0);
        checkOutput("post_abort_mode", WIDTH'(shift_mode), '0);
        checkOutput("post_abort_quotient", quotient, '0);
        prev_q = '0;
        prev_r = '0;
        return;
      end
      if (k == 1)            exp_mode = 2'b11;
      else if (k < exp_lat)  exp_mode = exp_dz ? 2'b00 : 2'b10;
      else                   exp_mode = 2'b00;
      checkOutput("shift_mode", WIDTH'(shift_mode), WIDTH'(exp_mode));
      checkOutput("busy", WIDTH'(busy), WIDTH'(k <= exp_lat));
      checkOutput("done", WIDTH'(done), WIDTH'(k == exp_lat));
      if (k == 1) begin
        checkOutput("hold_quotient", quotient, prev_q);
        checkOutput("hold_remainder", remainder, prev_r);
      end
      if (k >= exp_lat) begin
        checkOutput("quotient", quotient, exp_q);
        checkOutput("remainder", remainder, exp_r);
        checkOutput("div_by_zero", WIDTH'(div_by_zero), WIDTH'(exp_dz));
      end
    end
    start  = 1'b0;
    prev_q = exp_q;
    prev_r = exp_r;
  endtask

  // Main sequence: reset, directed cases, then randomized back-to-back ops
  initial begin
    logic [WIDTH-1:0] rdd;
    logic [WIDTH-1:0] rdv;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_quotient", quotient, '0);
    checkOutput("reset_remainder", remainder, '0);
    checkOutput("reset_busy", WIDTH'(busy), '0);
    checkOutput("reset_done", WIDTH'(done), '0);
    checkOutput("reset_mode", WIDTH'(shift_mode), '0);
    checkOutput("reset_dz", WIDTH'(div_by_zero), '0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", WIDTH'(busy), '0);
    prev_q = '0;
    prev_r = '0;

    applyStimulus(16'd100, 16'd7, 0, 0);
    applyStimulus(16'hFFFF, 16'd1, 0, 0);
    applyStimulus(16'd5, 16'd9, 0, 0);
    applyStimulus(16'h1234, 16'd0, 0, 0);
    applyStimulus(16'd1000, 16'd3, 6, 0);
    applyStimulus(16'hBEEF, 16'h0012, 0, 9);
    applyStimulus(16'd777, 16'd25, 0, 0);
    applyStimulus(16'h8000, 16'hFFFF, 0, 0);

    for (int n = 0; n < 24; n++) begin
      rdd = WIDTH'($urandom);
      if (n % 4 == 0) rdv = WIDTH'($urandom_range(1, 15));
      else            rdv = WIDTH'($urandom);
      if (n == 10) rdv = '0;
      applyStimulus(rdd, rdv, (n % 5 == 0) ? 4 : 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mathbox_div_sequencer.md
# mathbox_div_sequencer

Sequences a chain of 8-bit universal shift registers as the quotient register of a restoring binary divider for the Star Wars math box. Accepts a start request with dividend and divisor and drives the chain's mode controls (hold, shift-left, shift-right, load) and its serial input. Maintains the partial remainder and shift count, then reports quotient, remainder and completion to the math-box microsequencer. One operation runs at a time, with a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: operand width in bits; must be a multiple of 8 (one shift cell per byte).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  captured on an accepted start.
- `divisor`  in  WIDTH  captured on an accepted start.
- `busy`  out  1  high from the cycle after an accepted start until the cycle after done.
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  WIDTH  quotient chain contents.
- `remainder`  out  WIDTH  final remainder.
- `div_by_zero`  out  1  divisor was zero; valid with done, held until next accept.
- `shift_mode`  out  2  {S1,S0} presented to the chain: 00 hold, 01 shift right, 10 shift left, 11 load.

## Operation
- Reset: state IDLE; quotient, remainder, counter, div_by_zero = 0; busy = 0; done = 0; shift_mode = 00.
- IDLE: on start=1, capture divisor and go to LOAD. start=0 holds the state.
- LOAD (1 cycle): shift_mode=11 and the chain loads dividend. remainder_reg=0, counter=WIDTH, div_by_zero=0. Next state is SHIFT.
- SHIFT (WIDTH cycles): partial = {remainder_reg, chain MSB}, WIDTH+1 bits. trial = partial − {1'b0, divisor}, computed WIDTH+2 bits wide so the borrow is visible.
  - No borrow: remainder_reg = trial[WIDTH-1:0], DS0 = 1.
  - Borrow: remainder_reg = partial[WIDTH-1:0], DS0 = 0.
  - In both cases shift_mode = 10 and counter decrements.
  - When counter reaches 1, go to DONE.
- DONE (1 cycle): done=1, shift_mode=00, then return to IDLE.
- Outputs `quotient` and `remainder` hold their values until the next LOAD.
- start asserted in LOAD/SHIFT/DONE is ignored and is not queued.
- Reset asserted mid-operation aborts immediately to the reset values. There is no partial result.
- The shift-right mode (01) is never issued by this block.
- The chain's DS7 input is tied 0.

## Timing
- start accepted at edge N: LOAD is active at N+1, SHIFT covers N+2 … N+WIDTH+1, done is high at N+WIDTH+2.
- Latency is WIDTH+2 cycles (18 for WIDTH=16).
- busy is high N+1 … N+WIDTH+2 and low at N+WIDTH+3. The earliest next accept is at N+WIDTH+3.
- quotient/remainder are stable and valid from the done cycle onward.
- shift_mode is registered and aligned with the state it describes.

## Configuration
- `MATHBOX_DIV_ZERO_DETECT_EN` defined: in LOAD, a zero divisor sets div_by_zero=1 and jumps straight to DONE (latency 3). The outputs are then quotient = all ones and remainder = dividend.
- `MATHBOX_DIV_ZERO_DETECT_EN` undefined: div_by_zero is tied 0 and the full WIDTH-step algorithm runs. This naturally yields the same quotient and remainder, with normal latency.

## Structure
- Package `mathbox_div_pkg` holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- Sub-module `quot_shift_chain` holds WIDTH/8 cascaded 8-bit universal shift cells. It takes the mode, DS0 and parallel input, and returns the parallel output and MSB.
- The sequencer contains the FSM, counter, subtractor and remainder register.

## Test plan
- dividend=100, divisor=7, start at cycle 0 → done at cycle 18; quotient=14, remainder=2, div_by_zero=0. shift_mode sequence: 11 once, then 10 sixteen times, then 00.
- dividend=0xFFFF, divisor=1 → quotient=0xFFFF, remainder=0. dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=0x1234, divisor=0:
  - with the macro: done at cycle 3, quotient=0xFFFF, remainder=0x1234, div_by_zero=1;
  - without the macro: the same values at cycle 18 and div_by_zero=0.
- start pulsed during SHIFT with new operands → ignored; results match the first operation and only one done pulse occurs.
- reset asserted at cycle 9 of an operation → all outputs 0 and IDLE the next cycle; a fresh start then completes correctly.
- Back-to-back: start at the first cycle busy is low after done → accepted, second result correct, and the first result holds until the second LOAD.
